duty_ramp: RTL and testbench

DUTY_RAMP -- requirements
Module: duty_ramp

---
 rtl/duty_ramp.sv | 117 +++++++++++
 tb/tb_duty_ramp.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/duty_ramp.sv
// Frame-synchronous duty ramp: accepts a duty target and slews the PWM
// duty value toward it by at most STEP once per PWM frame.
module duty_ramp #(
  parameter int unsigned FRAME    = 2000000,
  parameter int unsigned MIN_DUTY = 50000,
  parameter int unsigned MAX_DUTY = 240000,
  parameter int unsigned STEP     = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [25:0] cmd_duty,
  output logic [25:0] duty_out,
  output logic        frame_tick,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RAMP
  } state_t;

  localparam logic [25:0] FRAME_C = 26'(FRAME);
  localparam logic [25:0] MIN_C   = 26'(MIN_DUTY);
  localparam logic [25:0] MAX_C   = 26'(MAX_DUTY);
  localparam logic [26:0] STEP_C  = 27'(STEP);

  state_t      state_q;
  logic [25:0] cnt_q;
  logic [25:0] cmd_q;
  logic [25:0] tgt_q;
  logic [25:0] duty_q;
  logic [25:0] tgt_d;
  logic [25:0] duty_d;
  logic [26:0] cur_w;
  logic [26:0] tgt_w;
  logic [26:0] up_w;
  logic [26:0] dn_w;
  logic        tick;
  logic        accept;

  assign tick       = (cnt_q == FRAME_C);
  assign cmd_ready  = (state_q != LOAD);
  assign accept     = cmd_valid & cmd_ready;
  assign busy       = (state_q != IDLE);
  assign frame_tick = tick;
  assign duty_out   = duty_q;

  always_comb begin
    tgt_d = cmd_q;
    if (cmd_q < MIN_C) begin
      tgt_d = MIN_C;
    end else if (cmd_q > MAX_C) begin
      tgt_d = MAX_C;
    end
  end

  // 27-bit math so duty+STEP never wraps; a zero duty jumps straight to target
  always_comb begin
    cur_w  = {1'b0, duty_q};
    tgt_w  = {1'b0, tgt_q};
    up_w   = cur_w + STEP_C;
    dn_w   = cur_w - STEP_C;
    duty_d = tgt_q;
    if ((duty_q != 26'd0) && (STEP_C != 27'd0)) begin
      if (cur_w < tgt_w) begin
        if (up_w < tgt_w) begin
          duty_d = up_w[25:0];
        end
      end else if (cur_w > tgt_w + STEP_C) begin
        duty_d = dn_w[25:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      tgt_q   <= '0;
      duty_q  <= '0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 26'd1;
      if (accept) begin
        cmd_q <= cmd_duty;
      end
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          tgt_q   <= tgt_d;
          state_q <= (tgt_d != duty_q) ? RAMP : IDLE;
        end
        RAMP: begin
          if (tick) begin
            duty_q <= duty_d;
            if (duty_d == tgt_q) begin
              state_q <= IDLE;
            end
          end
          // a new command overrides the return to IDLE
          if (accept) begin
            state_q <= LOAD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_duty_ramp.sv
// Bench for duty_ramp: two instances (STEP=2 and STEP=0) against a
// cycle-level arithmetic reference model, directed steps then random traffic.
module tb_duty_ramp;

  localparam int FR = 9;
  localparam int MN = 2;
  localparam int MX = 8;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic [25:0] cmd_duty;
  logic        rdy0, rdy1;
  logic        tick0, tick1;
  logic        busy0, busy1;
  logic [25:0] duty0, duty1;

  int checks = 0;
  int failures = 0;

  int m_cnt;
  int m_duty[2];
  int m_tgt[2];
  bit m_ramp[2];
  bit m_load;
  int m_pend;
  int m_step[2] = '{2, 0};

  duty_ramp #(.FRAME(FR), .MIN_DUTY(MN), .MAX_DUTY(MX), .STEP(2)) u0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy0),
    .cmd_duty(cmd_duty), .duty_out(duty0), .frame_tick(tick0),
    .busy(busy0)
  );

  duty_ramp #(.FRAME(FR), .MIN_DUTY(MN), .MAX_DUTY(MX), .STEP(0)) u1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
    .cmd_duty(cmd_duty), .duty_out(duty1), .frame_tick(tick1),
    .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [25:0] obs, input int exp);
    logic [25:0] e;
    e = 26'(exp);
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, e);
    end
  endtask

  function automatic int clampv(input int v);
    if (v < MN) return MN;
    if (v > MX) return MX;
    return v;
  endfunction

  function automatic int approach(input int d, input int t, input int s);
    if (d == 0 || s == 0) return t;
    if (d < t) return (d + s < t) ? d + s : t;
    return (d - s > t) ? d - s : t;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_load = 0;
    m_pend = 0;
    for (int i = 0; i < 2; i++) begin
      m_duty[i] = 0;
      m_tgt[i] = 0;
      m_ramp[i] = 0;
    end
  endtask

  task automatic model_edge(input bit v, input int d);
    bit tk;
    bit acc;
    tk = (m_cnt == FR);
    acc = v && !m_load;
    for (int i = 0; i < 2; i++) begin
      if (m_load) begin
        m_tgt[i] = clampv(m_pend);
        m_ramp[i] = (m_tgt[i] != m_duty[i]);
      end else if (m_ramp[i] && tk) begin
        m_duty[i] = approach(m_duty[i], m_tgt[i], m_step[i]);
        m_ramp[i] = (m_duty[i] != m_tgt[i]);
      end
    end
    m_load = 0;
    if (acc) begin
      m_pend = d;
      m_load = 1;
    end
    m_cnt = tk ? 0 : m_cnt + 1;
  endtask

  task automatic check_all();
    chk("duty0", duty0, m_duty[0]);
    chk("duty1", duty1, m_duty[1]);
    chk("tick0", {25'd0, tick0}, int'(m_cnt == FR));
    chk("tick1", {25'd0, tick1}, int'(m_cnt == FR));
    chk("ready0", {25'd0, rdy0}, int'(!m_load));
    chk("ready1", {25'd0, rdy1}, int'(!m_load));
    chk("busy0", {25'd0, busy0}, int'(m_load || m_ramp[0]));
    chk("busy1", {25'd0, busy1}, int'(m_load || m_ramp[1]));
  endtask

  task automatic step(input bit v, input int d);
    cmd_valid = v;
    cmd_duty = 26'(d);
    @(posedge clk);
    model_edge(v, d);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_all();
  endtask

  task automatic wait_cnt(input int n);
    int k;
    k = 0;
    while (m_cnt != n && k < 20) begin
      step(0, 0);
      k++;
    end
    chk("wait_cnt", 26'(m_cnt), n);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_duty = '0;
    model_reset();
    #2;
    chk("rst_duty", duty0, 0);
    chk("rst_tick", {25'd0, tick0}, 0);
    chk("rst_busy", {25'd0, busy0}, 0);
    chk("rst_ready", {25'd0, rdy0}, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all();

    // first command jumps from 0 at the first tick
    step(0, 0); step(0, 0); step(0, 0);
    step(1, 5);
    chk("load_ready", {25'd0, rdy0}, 0);
    step(0, 0);
    chk("ramp_ready", {25'd0, rdy0}, 1);
    wait_cnt(FR);
    step(0, 0);
    chk("jump5", duty0, 5);
    chk("idle5", {25'd0, busy0}, 0);

    // 5 -> 8 in two frames, no overshoot
    step(1, 8);
    wait_cnt(FR); step(0, 0);
    chk("ramp7", duty0, 7);
    chk("busy7", {25'd0, busy0}, 1);
    wait_cnt(FR); step(0, 0);
    chk("ramp8", duty0, 8);
    chk("idle8", {25'd0, busy0}, 0);

    // clamping
    step(1, 20);
    chk("clamp_hi_load", {25'd0, busy0}, 1);
    step(0, 0);
    chk("clamp_hi_idle", {25'd0, busy0}, 0);
    chk("clamp_hi_duty", duty0, 8);
    step(1, 0); step(0, 0);
    wait_cnt(FR); step(0, 0);
    chk("down6", duty0, 6);
    wait_cnt(FR); step(0, 0);
    chk("down4", duty0, 4);
    wait_cnt(FR); step(0, 0);
    chk("down2", duty0, 2);
    chk("down_idle", {25'd0, busy0}, 0);
    step(1, 2);
    chk("same_load", {25'd0, busy0}, 1);
    step(0, 0);
    chk("same_idle", {25'd0, busy0}, 0);
    chk("same_duty", duty0, 2);

    // retarget in the tick cycle; STEP=0 instance jumps
    step(1, 8); step(0, 0);
    wait_cnt(FR);
    step(1, 3);
    chk("retgt4", duty0, 4);
    chk("step0_8", duty1, 8);
    chk("retgt_load", {25'd0, rdy0}, 0);
    wait_cnt(FR); step(0, 0);
    chk("retgt3", duty0, 3);
    chk("retgt_idle", {25'd0, busy0}, 0);

    // reset mid-ramp
    step(1, 8); step(0, 0);
    wait_cnt(FR); step(0, 0);
    chk("pre_rst5", duty0, 5);
    step(0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_duty0", duty0, 0);
    chk("arst_duty1", duty1, 0);
    chk("arst_tick", {25'd0, tick0}, 0);
    chk("arst_busy", {25'd0, busy0}, 0);
    chk("arst_ready", {25'd0, rdy0}, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_all();
    k = 0;
    while (!tick0 && k < 30) begin
      step(0, 0);
      k++;
    end
    chk("tick_after_rst", 26'(k), 9);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, int'($urandom_range(0, 12)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
